// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and decoded-control bundle
// for the mini-MIPS execute-and-memory stage.
package mips_pkg;

   localparam int MEM_WORDS_DEF = 256;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_AND = 4'd0,
      ALU_OR  = 4'd1,
      ALU_ADD = 4'd2,
      ALU_XOR = 4'd3,
      ALU_NOR = 4'd4,
      ALU_SUB = 4'd6,
      ALU_SLT = 4'd7,
      ALU_SLL = 4'd8,
      ALU_SRL = 4'd9,
      ALU_SRA = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic    reg_dst;
      logic    alu_src;
      logic    reg_write;
      logic    mem_to_reg;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};

endpackage

// File: rtl/mips_exec_stage_if.sv
// Instruction-field / operand inputs and decoded-control / result outputs of the
// execute stage. master drives the instruction, slave is the execute stage.
interface mips_exec_stage_if;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [15:0] imm;

   logic        reg_dst;
   logic        reg_write;
   logic        mem_to_reg;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        jump;
   logic        branch_taken;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        zero;
   logic [31:0] wb_data;

   modport master (
      output opcode, funct, shamt, rs_data, rt_data, imm,
      input  reg_dst, reg_write, mem_to_reg, mem_read, mem_write, branch, jump,
             branch_taken, alu_ctrl, alu_result, zero, wb_data
   );

   modport slave (
      input  opcode, funct, shamt, rs_data, rt_data, imm,
      output reg_dst, reg_write, mem_to_reg, mem_read, mem_write, branch, jump,
             branch_taken, alu_ctrl, alu_result, zero, wb_data
   );

endinterface

// File: rtl/mips_dmem.sv
// Word-addressed data RAM: synchronous reset clears every word, store on the
// rising edge, combinational read gated by the read strobe (0 when idle).
module mips_dmem
   import mips_pkg::*;
#(
   parameter  int MEM_WORDS = MEM_WORDS_DEF,
   localparam int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_r [MEM_WORDS];

   // Storage: reset wipes the array and drops any store presented in that cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem_r[i] <= 32'd0;
         end
      end else if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   // Read port: sees the pre-edge contents, so a same-cycle store is not forwarded
   always_comb begin
      rdata = 32'd0;
      if (re) begin
         rdata = mem_r[addr];
      end else begin
         rdata = 32'd0;
      end
   end

endmodule

// File: rtl/mips_exec_stage.sv
// Single-cycle execute/memory stage: inline decoder and ALU plus data memory.
// Optional shifter (sll/srl/sra) built only when MIPS_SHIFT_EN is defined.
module mips_exec_stage
   import mips_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input logic              clk,
   input logic              reset,
   mips_exec_stage_if.slave bus
);

   localparam int AW = $clog2(MEM_WORDS);

   ctrl_t       ctrl_s;
   logic        rtype_ok_s;
   logic [31:0] imm_ext_s;
   logic [31:0] op_b_s;
   logic [31:0] alu_res_s;
   logic [31:0] mem_rdata_s;

   // Decoder: anything not recognised collapses to all-zero controls with ADD
   always_comb begin
      ctrl_s     = CTRL_NONE;
      rtype_ok_s = 1'b0;
      imm_ext_s  = {{16{bus.imm[15]}}, bus.imm};
      case (bus.opcode)
         OP_RTYPE: begin
            rtype_ok_s = 1'b1;
            case (bus.funct)
               FN_ADD:  ctrl_s.alu_op = ALU_ADD;
               FN_SUB:  ctrl_s.alu_op = ALU_SUB;
               FN_AND:  ctrl_s.alu_op = ALU_AND;
               FN_OR:   ctrl_s.alu_op = ALU_OR;
               FN_XOR:  ctrl_s.alu_op = ALU_XOR;
               FN_NOR:  ctrl_s.alu_op = ALU_NOR;
               FN_SLT:  ctrl_s.alu_op = ALU_SLT;
`ifdef MIPS_SHIFT_EN
               FN_SLL:  ctrl_s.alu_op = ALU_SLL;
               FN_SRL:  ctrl_s.alu_op = ALU_SRL;
               FN_SRA:  ctrl_s.alu_op = ALU_SRA;
`endif
               default: rtype_ok_s = 1'b0;
            endcase
            if (rtype_ok_s) begin
               ctrl_s.reg_dst   = 1'b1;
               ctrl_s.reg_write = 1'b1;
            end else begin
               ctrl_s = CTRL_NONE;
            end
         end
         OP_ADDI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
         end
         OP_SLTI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_op    = ALU_SLT;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            imm_ext_s        = {16'h0000, bus.imm};
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_op    = (bus.opcode == OP_ANDI) ? ALU_AND :
                               (bus.opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
         end
         OP_LW: begin
            ctrl_s.alu_src    = 1'b1;
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.mem_read   = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl_s.branch = 1'b1;
            ctrl_s.alu_op = ALU_SUB;
         end
         OP_J:    ctrl_s.jump = 1'b1;
         default: ctrl_s = CTRL_NONE;
      endcase
   end

   // ALU: wrap-around add/sub, signed set-less-than, shifts act on operand B
   always_comb begin
      op_b_s = ctrl_s.alu_src ? imm_ext_s : bus.rt_data;
      case (ctrl_s.alu_op)
         ALU_AND: alu_res_s = bus.rs_data & op_b_s;
         ALU_OR:  alu_res_s = bus.rs_data | op_b_s;
         ALU_XOR: alu_res_s = bus.rs_data ^ op_b_s;
         ALU_NOR: alu_res_s = ~(bus.rs_data | op_b_s);
         ALU_SUB: alu_res_s = bus.rs_data - op_b_s;
         ALU_SLT: alu_res_s = {31'd0, $signed(bus.rs_data) < $signed(op_b_s)};
`ifdef MIPS_SHIFT_EN
         ALU_SLL: alu_res_s = op_b_s << bus.shamt;
         ALU_SRL: alu_res_s = op_b_s >> bus.shamt;
         ALU_SRA: alu_res_s = $unsigned($signed(op_b_s) >>> bus.shamt);
`endif
         default: alu_res_s = bus.rs_data + op_b_s;
      endcase
   end

`ifndef MIPS_SHIFT_EN
   logic unused_shamt_s;
   assign unused_shamt_s = ^bus.shamt;
`endif

   mips_dmem #(.MEM_WORDS(MEM_WORDS)) u_dmem (
      .clk   (clk),
      .reset (reset),
      .we    (ctrl_s.mem_write),
      .re    (ctrl_s.mem_read),
      .addr  (alu_res_s[AW+1:2]),
      .wdata (bus.rt_data),
      .rdata (mem_rdata_s)
   );

   assign bus.reg_dst      = ctrl_s.reg_dst;
   assign bus.reg_write    = ctrl_s.reg_write;
   assign bus.mem_to_reg   = ctrl_s.mem_to_reg;
   assign bus.mem_read     = ctrl_s.mem_read;
   assign bus.mem_write    = ctrl_s.mem_write;
   assign bus.branch       = ctrl_s.branch;
   assign bus.jump         = ctrl_s.jump;
   assign bus.alu_ctrl     = ctrl_s.alu_op;
   assign bus.alu_result   = alu_res_s;
   assign bus.zero         = (alu_res_s == 32'd0);
   assign bus.branch_taken = ctrl_s.branch & (alu_res_s == 32'd0);
   assign bus.wb_data      = ctrl_s.mem_to_reg ? mem_rdata_s : alu_res_s;

endmodule

// File: tb/tb_mips_exec_stage.sv
// Directed plus randomized bench for mips_exec_stage against an instruction-level
// reference model with a 256-word memory array.
module tb_mips_exec_stage;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips_exec_stage_if bus();

   mips_exec_stage #(.MEM_WORDS(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mdl_mem [256];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One instruction: drive mid-cycle, check combinational outputs, then model the edge
   task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input string tag);
      logic [6:0]  ctl;   // reg_dst, reg_write, mem_to_reg, mem_read, mem_write, branch, jump
      logic [3:0]  aluc;
      logic [31:0] res, sx, zx, rd, wb;
      logic        legal;
      int          idx;
      ctl = 7'b0; aluc = 4'd2; res = a + b; legal = 1'b1;
      sx = {{16{im[15]}}, im};
      zx = {16'h0000, im};
      case (op)
         6'h00: begin
            case (fn)
               6'h20: begin aluc = 4'd2; res = a + b; end
               6'h22: begin aluc = 4'd6; res = a - b; end
               6'h24: begin aluc = 4'd0; res = a & b; end
               6'h25: begin aluc = 4'd1; res = a | b; end
               6'h26: begin aluc = 4'd3; res = a ^ b; end
               6'h27: begin aluc = 4'd4; res = ~(a | b); end
               6'h2A: begin aluc = 4'd7; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
`ifdef MIPS_SHIFT_EN
               6'h00: begin aluc = 4'd8;  res = b << sh; end
               6'h02: begin aluc = 4'd9;  res = b >> sh; end
               6'h03: begin aluc = 4'd10; res = $unsigned($signed(b) >>> sh); end
`endif
               default: legal = 1'b0;
            endcase
            if (legal) ctl = 7'b1100000;
         end
         6'h08: begin ctl = 7'b0100000; res = a + sx; end
         6'h0A: begin ctl = 7'b0100000; aluc = 4'd7; res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
         6'h0C: begin ctl = 7'b0100000; aluc = 4'd0; res = a & zx; end
         6'h0D: begin ctl = 7'b0100000; aluc = 4'd1; res = a | zx; end
         6'h0E: begin ctl = 7'b0100000; aluc = 4'd3; res = a ^ zx; end
         6'h23: begin ctl = 7'b0111000; res = a + sx; end
         6'h2B: begin ctl = 7'b0000100; res = a + sx; end
         6'h04: begin ctl = 7'b0000010; aluc = 4'd6; res = a - b; end
         6'h02: begin ctl = 7'b0000001; end
         default: begin ctl = 7'b0; end
      endcase
      idx = int'(res[9:2]);
      rd  = ctl[3] ? mdl_mem[idx] : 32'd0;
      wb  = ctl[4] ? rd : res;

      @(negedge clk);
      reset = rst;
      bus.opcode = op; bus.funct = fn; bus.shamt = sh;
      bus.rs_data = a; bus.rt_data = b; bus.imm = im;
      #1;
      chk({tag, ".ctl"}, {25'd0, bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.mem_read,
                          bus.mem_write, bus.branch, bus.jump}, {25'd0, ctl});
      chk({tag, ".alu_ctrl"}, {28'd0, bus.alu_ctrl}, {28'd0, aluc});
      chk({tag, ".taken"}, {31'd0, bus.branch_taken}, {31'd0, ctl[1] & (res == 32'd0)});
      if (op != 6'h02) begin
         chk({tag, ".alu_result"}, bus.alu_result, res);
         chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, res == 32'd0});
         chk({tag, ".wb_data"}, bus.wb_data, wb);
      end

      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 256; i++) mdl_mem[i] = 32'd0;
      end else if (ctl[2]) begin
         mdl_mem[idx] = b;
      end
   endtask

   initial begin
      logic [5:0]  ops [17];
      logic [5:0]  fns [12];
      logic [5:0]  op, fn;
      logic [31:0] a, b;
      logic [15:0] im;
      ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h23,
              6'h2B, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h01, 6'h10};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
              6'h01, 6'h3F};
      for (int i = 0; i < 256; i++) mdl_mem[i] = 32'd0;

      step(1'b1, 6'h00, 6'h20, 5'd0, 32'd5, 32'd3, 16'd0, "rst_add");
      step(1'b0, 6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 16'd0, "lw0_after_reset");
      step(1'b0, 6'h00, 6'h20, 5'd0, 32'd5, 32'd3, 16'd0, "add");
      step(1'b0, 6'h00, 6'h22, 5'd0, 32'd5, 32'd3, 16'd0, "sub");
      step(1'b0, 6'h00, 6'h22, 5'd0, 32'd3, 32'd5, 16'd0, "sub_neg");
      step(1'b0, 6'h0D, 6'h00, 5'd0, 32'd0, 32'd0, 16'h8001, "ori_zext");
      step(1'b0, 6'h08, 6'h00, 5'd0, 32'd0, 32'd0, 16'hFFFF, "addi_sext");
      step(1'b0, 6'h0A, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd0, 16'h0000, "slti_neg");
      step(1'b0, 6'h2B, 6'h00, 5'd0, 32'd0, 32'd42, 16'd4, "sw4");
      step(1'b0, 6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 16'd4, "lw4");
      step(1'b0, 6'h23, 6'h00, 5'd0, 32'h0000_0404, 32'd0, 16'd0, "lw_wrap");
      step(1'b0, 6'h23, 6'h00, 5'd0, 32'd6, 32'd0, 16'd0, "lw_lowbits");
      step(1'b0, 6'h04, 6'h00, 5'd0, 32'd7, 32'd7, 16'd0, "beq_eq");
      step(1'b0, 6'h04, 6'h00, 5'd0, 32'd7, 32'd8, 16'd0, "beq_ne");
      step(1'b0, 6'h2B, 6'h00, 5'd0, 32'd0, 32'h1234, 16'd8, "sw8");
      step(1'b1, 6'h08, 6'h00, 5'd0, 32'd1, 32'd0, 16'd1, "mid_reset");
      step(1'b0, 6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 16'd8, "lw8_cleared");
      step(1'b1, 6'h2B, 6'h00, 5'd0, 32'd0, 32'h55, 16'd12, "sw_in_reset");
      step(1'b0, 6'h23, 6'h00, 5'd0, 32'd0, 32'd0, 16'd12, "lw12_not_stored");
      step(1'b0, 6'h3F, 6'h00, 5'd0, 32'd1, 32'd2, 16'd3, "illegal_op");
      step(1'b0, 6'h02, 6'h00, 5'd0, 32'd1, 32'd2, 16'd3, "jump");
      step(1'b0, 6'h00, 6'h03, 5'd4, 32'd0, 32'h8000_0000, 16'd0, "sra");
      step(1'b0, 6'h00, 6'h02, 5'd4, 32'd0, 32'h8000_0000, 16'd0, "srl");
      step(1'b0, 6'h00, 6'h00, 5'd4, 32'd0, 32'h8000_0000, 16'd0, "sll");

      for (int n = 0; n < 400; n++) begin
         op = ops[$urandom_range(0, 16)];
         fn = fns[$urandom_range(0, 11)];
         a  = $urandom();
         b  = $urandom();
         im = 16'($urandom());
         if (op == 6'h23 || op == 6'h2B) begin
            a  = 32'($urandom_range(0, 15)) * 32'd4;
            im = 16'($urandom_range(0, 7)) * 16'd4;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom() & 32'hFFFF_FC00);
         end
         if (op == 6'h04 && $urandom_range(0, 1) == 0) b = a;
         step(($urandom_range(0, 49) == 0), op, fn, 5'($urandom()), a, b, im, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
